// File: rtl/vreg_port_arbiter_pkg.sv
// Shared core constants and types for the vector register port arbiter.
package vreg_port_arbiter_pkg;

   localparam int VECTOR_REG_DEPTH  = 16;
   localparam int VECTOR_REG_WIDTH  = 16;
   localparam int NUM_OF_VECTOR_REG = 32;
   localparam int NUM_VREG_REQ      = 5;
   localparam int LSU_REQ_ID        = 4;
   localparam int VREG_MAX_BURST    = 8;

   typedef enum logic {
      ARB_IDLE,
      ARB_BURST
   } arb_state_e;

   function automatic int wrap_inc(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/vreg_port_arbiter_rr_lock_arbiter.sv
// Round-robin arbiter with bounded burst lock for one register port.
// VREG_ARB_LSU_PRIORITY_EN: the top requester wins arbitration from IDLE.
module rr_lock_arbiter
   import vreg_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = NUM_VREG_REQ,
   parameter int MAX_BURST = VREG_MAX_BURST
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [NUM_REQ-1:0] i_last,
   output logic [NUM_REQ-1:0] o_gnt
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam int LSU_ID = NUM_REQ - 1;
`ifdef VREG_ARB_LSU_PRIORITY_EN
   localparam bit LSU_PRIO = 1'b1;
`else
   localparam bit LSU_PRIO = 1'b0;
`endif

   arb_state_e        r_state, w_state_nxt;
   logic [IW-1:0]     r_ptr, w_ptr_nxt;
   logic [IW-1:0]     r_owner, w_owner_nxt;
   logic [CW-1:0]     r_cnt, w_cnt_nxt;
   logic [NUM_REQ-1:0] w_gnt;
   logic              w_any;
   logic [IW-1:0]     w_win;

   // Reverse scan so the requester closest to ptr is assigned last.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_req[(int'(r_ptr) + k) % NUM_REQ]) begin
            w_any = 1'b1;
            w_win = IW'((int'(r_ptr) + k) % NUM_REQ);
         end
      end
      if (LSU_PRIO && i_req[LSU_ID]) begin
         w_any = 1'b1;
         w_win = IW'(LSU_ID);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      w_gnt       = '0;
      unique case (r_state)
         ARB_IDLE: begin
            if (w_any) begin
               w_gnt[w_win] = 1'b1;
               if (!i_last[w_win] && MAX_BURST > 1) begin
                  w_state_nxt = ARB_BURST;
                  w_owner_nxt = w_win;
                  w_cnt_nxt   = CW'(1);
               end else if (!(LSU_PRIO && int'(w_win) == LSU_ID)) begin
                  w_ptr_nxt = IW'(wrap_inc(int'(w_win), NUM_REQ));
               end
            end
         end
         ARB_BURST: begin
            if (i_req[r_owner]) begin
               w_gnt[r_owner] = 1'b1;
               w_cnt_nxt = r_cnt + CW'(1);
            end
            if (!i_req[r_owner] || i_last[r_owner] ||
                int'(r_cnt) + 1 >= MAX_BURST) begin
               w_state_nxt = ARB_IDLE;
               w_cnt_nxt   = '0;
               if (!(LSU_PRIO && int'(r_owner) == LSU_ID))
                  w_ptr_nxt = IW'(wrap_inc(int'(r_owner), NUM_REQ));
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   assign o_gnt = i_reset ? '0 : w_gnt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ARB_IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/vreg_port_arbiter.sv
// Shares one vector register's read and write ports between lanes and LSU.
// VREG_ARB_LSU_PRIORITY_EN: LSU wins new arbitrations on both sides.
module vreg_port_arbiter
   import vreg_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = NUM_VREG_REQ,
   parameter int ADDR_W    = $clog2(VECTOR_REG_DEPTH),
   parameter int DATA_W    = VECTOR_REG_WIDTH,
   parameter int MAX_BURST = VREG_MAX_BURST
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic [NUM_REQ-1:0]             i_rd_req,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] i_rd_addr,
   input  logic [NUM_REQ-1:0]             i_rd_last,
   output logic [NUM_REQ-1:0]             o_rd_gnt,
   output logic [NUM_REQ-1:0]             o_rd_rsp_vld,
   output logic [DATA_W-1:0]              o_rd_rsp_data,
   input  logic [NUM_REQ-1:0]             i_wr_req,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] i_wr_addr,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] i_wr_data,
   input  logic [NUM_REQ-1:0]             i_wr_last,
   output logic [NUM_REQ-1:0]             o_wr_gnt,
   output logic [ADDR_W-1:0]              o_read_addr,
   input  logic [DATA_W-1:0]              i_reg_data,
   output logic                           o_write,
   output logic [ADDR_W-1:0]              o_write_addr,
   output logic [DATA_W-1:0]              o_write_data
);

   logic [NUM_REQ-1:0] w_rd_beat, w_wr_beat;
   logic [NUM_REQ-1:0] r_rsp_vld;
   logic [ADDR_W-1:0]  r_read_addr, w_rd_addr;
   logic [ADDR_W-1:0]  w_wr_addr;
   logic [DATA_W-1:0]  w_wr_data;

   rr_lock_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .MAX_BURST (MAX_BURST)
   ) u_rd_arb (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_req   (i_rd_req),
      .i_last  (i_rd_last),
      .o_gnt   (o_rd_gnt)
   );

   rr_lock_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .MAX_BURST (MAX_BURST)
   ) u_wr_arb (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_req   (i_wr_req),
      .i_last  (i_wr_last),
      .o_gnt   (o_wr_gnt)
   );

   assign w_rd_beat = i_rd_req & o_rd_gnt;
   assign w_wr_beat = i_wr_req & o_wr_gnt;

   // Grants are one-hot, so an OR-mux selects the winner.
   always_comb begin
      w_rd_addr = '0;
      w_wr_addr = '0;
      w_wr_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_rd_beat[i]) w_rd_addr = w_rd_addr | i_rd_addr[i];
         if (w_wr_beat[i]) begin
            w_wr_addr = w_wr_addr | i_wr_addr[i];
            w_wr_data = w_wr_data | i_wr_data[i];
         end
      end
   end

   assign o_read_addr = i_reset ? '0 :
                        (|w_rd_beat) ? w_rd_addr : r_read_addr;
   assign o_write      = |w_wr_beat;
   assign o_write_addr = w_wr_addr;
   assign o_write_data = w_wr_data;

   // Gating with reset drops the response of a beat issued just before it.
   assign o_rd_rsp_vld  = i_reset ? '0 : r_rsp_vld;
   assign o_rd_rsp_data = i_reset ? '0 : i_reg_data;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rsp_vld   <= '0;
         r_read_addr <= '0;
      end else begin
         r_rsp_vld   <= w_rd_beat;
         r_read_addr <= o_read_addr;
      end
   end

endmodule

// File: tb/tb_vreg_port_arbiter.sv
// Directed scoreboard bench for vreg_port_arbiter.
module tb_vreg_port_arbiter;

   logic clk = 1'b0;
   logic reset;
   logic [4:0]       rd_req, rd_last, rd_gnt, rd_vld;
   logic [4:0][3:0]  rd_addr;
   logic [15:0]      rsp_data;
   logic [4:0]       wr_req, wr_last, wr_gnt;
   logic [4:0][3:0]  wr_addr;
   logic [4:0][15:0] wr_data;
   logic [3:0]       read_addr, write_addr;
   logic [15:0]      reg_data = 16'h0;
   logic             write;
   logic [15:0]      write_data;

   logic [15:0] rf [16];
   logic        rf_ok = 1'b0;
   logic [15:0] mmem [16];

   typedef struct {
      int          id;
      logic [15:0] data;
   } rsp_t;
   rsp_t sb[$];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   vreg_port_arbiter dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_rd_req      (rd_req),
      .i_rd_addr     (rd_addr),
      .i_rd_last     (rd_last),
      .o_rd_gnt      (rd_gnt),
      .o_rd_rsp_vld  (rd_vld),
      .o_rd_rsp_data (rsp_data),
      .i_wr_req      (wr_req),
      .i_wr_addr     (wr_addr),
      .i_wr_data     (wr_data),
      .i_wr_last     (wr_last),
      .o_wr_gnt      (wr_gnt),
      .o_read_addr   (read_addr),
      .i_reg_data    (reg_data),
      .o_write       (write),
      .o_write_addr  (write_addr),
      .o_write_data  (write_data)
   );

   always @(posedge clk) begin
      if (!rf_ok) begin
         for (int i = 0; i < 16; i++) rf[i] <= 16'h1000 | 16'(i);
         rf_ok <= 1'b1;
      end else begin
         reg_data <= rf[read_addr];
         if (write) rf[write_addr] <= write_data;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic int oh2i(input logic [4:0] v);
      for (int i = 0; i < 5; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic tick(input logic [4:0] erd, input logic [4:0] ewr);
      rsp_t e;
      int l;
      #4;
      chk("rd_gnt", 32'(rd_gnt), 32'(erd));
      chk("wr_gnt", 32'(wr_gnt), 32'(ewr));
      if (reset) begin
         chk("rst_vld", 32'(rd_vld), 0);
         chk("rst_raddr", 32'(read_addr), 0);
         chk("rst_rdata", 32'(rsp_data), 0);
         sb.delete();
      end else if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("rd_vld", 32'(rd_vld), 32'(1) << e.id);
         chk("rd_data", 32'(rsp_data), 32'(e.data));
      end else begin
         chk("rd_vld_idle", 32'(rd_vld), 0);
      end
      if (!reset && erd != 0) begin
         l = oh2i(erd);
         chk("read_addr", 32'(read_addr), 32'(rd_addr[l]));
         e.id = l;
         e.data = mmem[rd_addr[l]];
         sb.push_back(e);
      end
      chk("write", 32'(write), 32'(ewr != 0));
      if (ewr != 0) begin
         l = oh2i(ewr);
         chk("write_addr", 32'(write_addr), 32'(wr_addr[l]));
         chk("write_data", 32'(write_data), 32'(wr_data[l]));
         mmem[wr_addr[l]] = wr_data[l];
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int beat;
      for (int i = 0; i < 16; i++) mmem[i] = 16'h1000 | 16'(i);
      reset = 1'b1;
      rd_req = '0; rd_last = '1; rd_addr = '0;
      wr_req = '0; wr_last = '1; wr_addr = '0; wr_data = '0;
      @(posedge clk);
      #1;
      tick(5'b0, 5'b0);
      tick(5'b0, 5'b0);
      reset = 1'b0;

      rd_addr[0] = 4'd3; rd_addr[2] = 4'd7; rd_addr[4] = 4'd9;
      rd_req = 5'b10101;
      tick(5'b00001, 5'b0);
      rd_req = 5'b10100;
      tick(5'b00100, 5'b0);
      rd_req = 5'b10000;
      tick(5'b10000, 5'b0);
      rd_req = 5'b0;
      tick(5'b0, 5'b0);
      chk("raddr_hold", 32'(read_addr), 9);
      tick(5'b0, 5'b0);

      rd_last = '0; rd_last[3] = 1'b1; rd_addr[3] = 4'd11;
      beat = 1;
      for (int c = 1; c <= 13; c++) begin
         rd_req = (c <= 9) ? 5'b01010 : 5'b00010;
         rd_addr[1] = 4'(beat);
         rd_last[1] = (beat == 12);
         if (c == 9) tick(5'b01000, 5'b0);
         else begin
            tick(5'b00010, 5'b0);
            beat++;
         end
      end
      rd_req = 5'b0; rd_last = '1;
      tick(5'b0, 5'b0);

      rd_req = 5'b00100; rd_addr[2] = 4'd5;
      wr_req = 5'b00001; wr_addr[0] = 4'd5; wr_data[0] = 16'hA5A5;
      tick(5'b00100, 5'b00001);
      wr_req = 5'b0;
      tick(5'b00100, 5'b0);
      rd_req = 5'b0;
      tick(5'b0, 5'b0);

      wr_last = '0; wr_last[3] = 1'b1;
      wr_addr[3] = 4'd12; wr_data[3] = 16'h3333;
      wr_req = 5'b01100;
      wr_addr[2] = 4'd9; wr_data[2] = 16'h2001;
      tick(5'b0, 5'b00100);
      wr_addr[2] = 4'd10; wr_data[2] = 16'h2002;
      tick(5'b0, 5'b00100);
      wr_req = 5'b01000;
      tick(5'b0, 5'b0);
      tick(5'b0, 5'b01000);
      wr_req = 5'b0; wr_last = '1;
      tick(5'b0, 5'b0);

      rd_last = '0; rd_req = 5'b00010;
      for (int b = 1; b <= 3; b++) begin
         rd_addr[1] = 4'(8 + b);
         tick(5'b00010, 5'b0);
      end
      rd_addr[1] = 4'd12;
      reset = 1'b1; rd_req = 5'b00111;
      tick(5'b0, 5'b0);
      reset = 1'b0; rd_last = '1;
      rd_addr[0] = 4'd1; rd_addr[2] = 4'd2;
      tick(5'b00001, 5'b0);
      rd_req = 5'b00110;
      tick(5'b00010, 5'b0);
      rd_req = 5'b0;
      tick(5'b0, 5'b0);

      rd_addr[0] = 4'd0; rd_addr[1] = 4'd1; rd_addr[4] = 4'd4;
      rd_req = 5'b10011;
      tick(5'b10000, 5'b0);
      rd_req = 5'b00011;
      tick(5'b00001, 5'b0);
      rd_req = 5'b00010;
      tick(5'b00010, 5'b0);
      rd_req = 5'b0;
      tick(5'b0, 5'b0);
      rd_last = '0; rd_req = 5'b00001;
      tick(5'b00001, 5'b0);
      rd_req = 5'b10001;
      tick(5'b00001, 5'b0);
      rd_last[0] = 1'b1;
      tick(5'b00001, 5'b0);
      rd_last = '1; rd_req = 5'b10000;
      tick(5'b10000, 5'b0);
      rd_req = 5'b10100; rd_addr[2] = 4'd6;
`ifdef VREG_ARB_LSU_PRIORITY_EN
      tick(5'b10000, 5'b0);
      rd_req = 5'b00100;
      tick(5'b00100, 5'b0);
`else
      tick(5'b00100, 5'b0);
      rd_req = 5'b10000;
      tick(5'b10000, 5'b0);
`endif
      rd_req = 5'b0;
      tick(5'b0, 5'b0);
      tick(5'b0, 5'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vreg_port_arbiter.md
# vreg_port_arbiter

Per-vector-register port arbiter: shares the single read port and single write port of one vector register between NUM_REQ requesters (lanes 0..3 plus the load/store unit). Read and write sides are arbitrated independently with round-robin and bounded burst locking. Instantiated once per vector register (NUM_OF_VECTOR_REG instances) between the crossbar and the vector register array.

## Interface
Parameters:
- NUM_REQ, 5: requesters; index NUM_REQ-1 is the LSU.
- ADDR_W, $clog2(VECTOR_REG_DEPTH): element address width.
- DATA_W, VECTOR_REG_WIDTH: element data width.
- MAX_BURST, 8: maximum beats one requester holds a side before forced release.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  NUM_REQ  per-requester read request.
- rd_addr  in  NUM_REQ x ADDR_W  per-requester read element address.
- rd_last  in  NUM_REQ  marks the final beat of a read burst.
- rd_gnt  out  NUM_REQ  one-hot read grant; the beat transfers when rd_req & rd_gnt.
- rd_rsp_vld  out  NUM_REQ  one-hot read data valid.
- rd_rsp_data  out  DATA_W  read data, broadcast to all requesters.
- wr_req, wr_addr, wr_data, wr_last, wr_gnt: write-side equivalents (wr_data is NUM_REQ x DATA_W).
- read_addr  out  ADDR_W  to vector register.
- reg_data  in  DATA_W  from vector register; valid one cycle after read_addr.
- write  out  1  register write enable.
- write_addr  out  ADDR_W  register write address.
- write_data  out  DATA_W  register write data.

## Operation
- Each side has an FSM with two states:
  - IDLE: if any request is pending, select a winner by round-robin, starting the search at ptr. The winner is granted in the same cycle. If its last flag is 0, move to BURST with owner = winner and beat_cnt = 1.
  - BURST: grant only the owner, and only while the owner requests; beat_cnt increments on each beat. Return to IDLE on any of these:
    - a beat with last = 1;
    - beat_cnt reaching MAX_BURST on the current beat;
    - the owner deasserting its request (no grant is issued that cycle).
- ptr update: on every release, ptr = (owner+1) mod NUM_REQ. After a single-beat grant from IDLE, ptr = (winner+1) mod NUM_REQ.
- A forced release at MAX_BURST re-arbitrates the next cycle from ptr, even if the former owner still requests.
- Read path:
  - read_addr = rd_addr of the granted requester. It holds its previous value when no grant.
  - rd_rsp_vld[i] is registered: asserted one cycle after a read beat by i.
  - rd_rsp_data = reg_data.
- Write path:
  - write = |(wr_req & wr_gnt).
  - write_addr and write_data are muxed from the granted requester in the same cycle.
- A read and a write to the same address in the same cycle: the read returns the old data. There is no forwarding.
- Grant vectors are always one-hot or zero.

## Timing
- Grant: combinational from request and state, in the same cycle. Read data: 1-cycle latency. Throughput: one beat per cycle per side.
- Reset values: state IDLE, ptr 0, beat_cnt 0, owner 0. All grants, rd_rsp_vld, write, read_addr, write_addr, write_data and rd_rsp_data are 0.
- Reset asserted mid-burst: grants are 0 in the following cycle, the lock is dropped, and any pending rd_rsp_vld is cleared.
- The rd_rsp_vld of a beat issued in the cycle before reset asserts is suppressed.

## Configuration
- VREG_ARB_LSU_PRIORITY_EN defined: in IDLE, an LSU request (index NUM_REQ-1) wins over round-robin. A lane burst in progress is not preempted. ptr is unchanged by LSU grants.
- VREG_ARB_LSU_PRIORITY_EN undefined: the LSU is a normal round-robin participant.

## Structure
- The shared core package holds:
  - VECTOR_REG_DEPTH, VECTOR_REG_WIDTH, NUM_OF_VECTOR_REG;
  - new constants NUM_VREG_REQ = 5, LSU_REQ_ID = 4, VREG_MAX_BURST = 8;
  - typedef enum arb_state_e {ARB_IDLE, ARB_BURST}.
- Sub-module rr_lock_arbiter holds the FSM, ptr, owner and beat_cnt. It is instantiated twice, once for the read side and once for the write side; the data and address muxes stay in the top module.

## Test plan
- Reset, then read requests from requesters 0, 2 and 4 at once, all single-beat. Grants follow 0, 2, 4 on consecutive cycles. rd_rsp_vld follows one cycle behind each grant, carrying the data at addresses 3, 7 and 9.
- Lane 1 requests a 12-beat read burst (rd_last on beat 12) while lane 3 is also requesting. Lane 1 gets 8 beats, lane 3 is granted in cycle 9, and lane 1 resumes afterwards.
- Lane 0 writes addr 5 = 0xA5A5 while lane 2 reads addr 5 in the same cycle. The read returns the old value. A read the next cycle returns 0xA5A5.
- Lane 2 drops wr_req at beat 3 of a write burst. Grant is 0 that cycle, and the next cycle lane 3 is granted (ptr = 3).
- Reset asserted during beat 4 of a read burst. The next cycle all grants and rd_rsp_vld are 0. After reset, lane 0 is granted first (ptr = 0).
- With VREG_ARB_LSU_PRIORITY_EN defined, lanes 0 and 1 plus the LSU request together. The LSU is granted first, then lanes 0 and 1. A lane-0 burst already in progress is not preempted by the LSU.
